// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Holds register-file geometry and the requester id enum.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Busy scoreboard: one bit per register owed by the memory path.
// Ports: set_i/set_rd_i, clr_i/clr_rd_i, chk_i + rs1/rs2/rd -> stall_o, busy_o.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic                  chk_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  stall_o,
  output logic [NUM_REGS-1:0]   busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_rd_i] = 1'b0;
    if (set_i) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // rd term catches WAW against an outstanding load.
  assign stall_o = chk_i & (busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rd_i]);
  assign busy_o  = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and memory writebacks.
// Macro RR_ARB_EN: round-robin on contention; otherwise memory wins.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [N-1:0]          alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [N-1:0]          mem_data,
  output logic                  mem_ready,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] iss_rs1,
  input  logic [REG_ADDR_W-1:0] iss_rs2,
  output logic                  iss_stall,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [N-1:0]          WriteData,
  output logic [NUM_REGS-1:0]   busy
);

  logic                  mem_win;
  logic                  grant;
  logic [REG_ADDR_W-1:0] gnt_rd;
  logic [N-1:0]          gnt_data;

  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [N-1:0]          wdat_q, wdat_d;

`ifdef RR_ARB_EN
  // Last granted requester; the other one wins the next tie.
  req_id_e last_q, last_d;

  assign mem_win = mem_valid & (!alu_valid | (last_q == REQ_ALU));

  always_comb begin
    last_d = last_q;
    if (alu_ready) last_d = REQ_ALU;
    if (mem_ready) last_d = REQ_MEM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= REQ_MEM;
    else      last_q <= last_d;
  end
`else
  assign mem_win = mem_valid;
`endif

  // Readies stay low while reset is held.
  assign mem_ready = rst & mem_win;
  assign alu_ready = rst & alu_valid & !mem_win;
  assign grant     = alu_ready | mem_ready;

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    unique case (1'b1)
      mem_ready: begin
        gnt_rd   = mem_rd;
        gnt_data = mem_data;
      end
      alu_ready: begin
        gnt_rd   = alu_rd;
        gnt_data = alu_data;
      end
      default: ;
    endcase
  end

  // rd=0 completes the handshake but never writes.
  always_comb begin
    wen_d  = 1'b0;
    wreg_d = wreg_q;
    wdat_d = wdat_q;
    if (grant && gnt_rd != '0) begin
      wen_d  = 1'b1;
      wreg_d = gnt_rd;
      wdat_d = gnt_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q  <= 1'b0;
      wreg_q <= '0;
      wdat_q <= '0;
    end else begin
      wen_q  <= wen_d;
      wreg_q <= wreg_d;
      wdat_q <= wdat_d;
    end
  end

  assign RegWrite  = wen_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdat_q;

  logic sb_set;

  assign sb_set = iss_valid & iss_long & !iss_stall & (iss_rd != '0);

  wb_scoreboard u_sb (
    .clk_i    (clk),
    .rst_ni   (rst),
    .set_i    (sb_set),
    .set_rd_i (iss_rd),
    .clr_i    (mem_ready),
    .clr_rd_i (mem_rd),
    .chk_i    (iss_valid),
    .rs1_i    (iss_rs1),
    .rs2_i    (iss_rs2),
    .rd_i     (iss_rd),
    .stall_o  (iss_stall),
    .busy_o   (busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Expectations follow RR_ARB_EN when defined, fixed priority otherwise.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        iss_valid;
  logic        iss_long;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_stall;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] busy;

  int n_run  = 0;
  int n_fail = 0;

`ifdef RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    alu_data  = 32'h11;
    mem_valid = 1'b1;
    mem_rd    = 5'd2;
    mem_data  = 32'h22;
    iss_valid = 1'b0;
    iss_long  = 1'b0;
    iss_rd    = '0;
    iss_rs1   = '0;
    iss_rs2   = '0;

    tick();
    tick();
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_writereg", {27'd0, WriteReg}, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_busy", busy, 32'd0);

    // Release with both valid: four contention cycles.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic alu_w;
      alu_w = RR ? (i % 2 == 0) : 1'b0;
      #1;
      chk($sformatf("cont%0d_alu_ready", i), {31'd0, alu_ready},
          {31'd0, alu_w});
      chk($sformatf("cont%0d_mem_ready", i), {31'd0, mem_ready},
          {31'd0, !alu_w});
      tick();
      chk($sformatf("cont%0d_regwrite", i), {31'd0, RegWrite}, 32'd1);
      chk($sformatf("cont%0d_writereg", i), {27'd0, WriteReg},
          alu_w ? 32'd1 : 32'd2);
      chk($sformatf("cont%0d_writedata", i), WriteData,
          alu_w ? 32'h11 : 32'h22);
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;

    // Single ALU request.
    tick();
    chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h0000_00AA;
    #1;
    chk("single_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    chk("single_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("single_writereg", {27'd0, WriteReg}, 32'd5);
    chk("single_writedata", WriteData, 32'hAA);
    tick();
    chk("single_pulse_end", {31'd0, RegWrite}, 32'd0);
    chk("single_hold_reg", {27'd0, WriteReg}, 32'd5);
    chk("single_hold_data", WriteData, 32'hAA);

    // Long issue to r7 sets busy.
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_rd    = 5'd7;
    #1;
    chk("sb_set_nostall", {31'd0, iss_stall}, 32'd0);
    tick();
    iss_valid = 1'b0;
    chk("sb_busy7", busy, 32'h0000_0080);

    // Dependent issue stalls and leaves the scoreboard alone.
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_rd    = 5'd3;
    iss_rs1   = 5'd7;
    #1;
    chk("sb_raw_stall", {31'd0, iss_stall}, 32'd1);
    tick();
    chk("sb_stalled_nochg", busy, 32'h0000_0080);

    // WAW on r7 also stalls.
    iss_rs1 = 5'd0;
    iss_rd  = 5'd7;
    #1;
    chk("sb_waw_stall", {31'd0, iss_stall}, 32'd1);

    // Memory writeback to r7 clears busy next cycle.
    iss_long  = 1'b0;
    iss_rd    = 5'd3;
    iss_rs1   = 5'd7;
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'h77;
    #1;
    chk("sb_clr_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("sb_clr_stall_T", {31'd0, iss_stall}, 32'd1);
    tick();
    mem_valid = 1'b0;
    chk("sb_clr_busy", busy, 32'd0);
    chk("sb_clr_stall", {31'd0, iss_stall}, 32'd0);
    chk("sb_clr_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("sb_clr_writereg", {27'd0, WriteReg}, 32'd7);
    chk("sb_clr_writedata", WriteData, 32'h77);
    iss_valid = 1'b0;
    iss_rs1   = 5'd0;

    // Same-cycle set and clear on r9: set wins.
    mem_valid = 1'b1;
    mem_rd    = 5'd9;
    mem_data  = 32'h99;
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_rd    = 5'd9;
    #1;
    chk("sc_stall", {31'd0, iss_stall}, 32'd0);
    chk("sc_mem_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    mem_valid = 1'b0;
    chk("sc_busy9", busy, 32'h0000_0200);

    // ALU rd=0 and long issue to r0: no write, busy[0] stays 0.
    iss_rd    = 5'd0;
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hFF;
    #1;
    chk("r0_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    iss_valid = 1'b0;
    chk("r0_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("r0_busy", busy, 32'h0000_0200);
    chk("r0_hold_reg", {27'd0, WriteReg}, 32'd9);

    // Mid-operation reset drops the in-flight write.
    alu_valid = 1'b1;
    alu_rd    = 5'd4;
    alu_data  = 32'h44;
    tick();
    chk("mid_regwrite_pre", {31'd0, RegWrite}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("mid_writereg", {27'd0, WriteReg}, 32'd0);
    chk("mid_writedata", WriteData, 32'd0);
    chk("mid_busy", busy, 32'd0);
    chk("mid_alu_ready", {31'd0, alu_ready}, 32'd0);
    alu_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_regwrite", {31'd0, RegWrite}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback controller for the 32-entry register file. Shares the file's single write port between the single-cycle ALU result path and the long-latency memory/load path. Keeps a per-register busy scoreboard so the issue stage stalls on operands still owed by the memory path. Drives the register file's RegWrite/WriteReg/WriteData from registers, and sits between the execute/memory stages and the register file.

## Interface
Parameters:
- N, 32, data width; matches the register file width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- alu_valid  in  1  ALU writeback request
- alu_rd  in  5  ALU destination register
- alu_data  in  N  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  memory-path writeback request
- mem_rd  in  5  memory destination register
- mem_data  in  N  load result
- mem_ready  out  1  memory request accepted this cycle
- iss_valid  in  1  instruction issuing this cycle
- iss_long  in  1  issuing instruction writes back via the memory path
- iss_rd, iss_rs1, iss_rs2  in  5 each  issuing destination and sources
- iss_stall  out  1  hold issue; combinational
- RegWrite  out  1  register file write enable; registered
- WriteReg  out  5  register file write address; registered
- WriteData  out  N  register file write data; registered
- busy  out  32  scoreboard; bit i = register i owed by the memory path

## Operation
- Request handshake: a request transfers in a cycle when valid and ready are both 1.
  - Ready may depend combinationally on both valid inputs.
  - A requester holds valid, rd and data stable until accepted.
- Arbitration, when exactly one requester is valid: it is granted.
- Arbitration, when both are valid: round-robin.
  - The requester not granted most recently wins.
  - The pointer updates only on an actual grant.
- No valid requests: both ready outputs are 0; the write registers load RegWrite=0 and hold WriteReg/WriteData.
- Accepted request with rd=0: completes the handshake; next-cycle RegWrite=0.
- Accepted request with rd≠0: next cycle RegWrite=1, WriteReg=rd, WriteData=data.
- Scoreboard set: busy[iss_rd] is set when iss_valid, iss_long, !iss_stall and iss_rd≠0 are all true.
- Scoreboard clear: busy[mem_rd] is cleared on an accepted memory request.
- Set and clear on the same register in the same cycle: set wins.
- busy[0] is always 0.
- iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]). The iss_rd term covers WAW. A stalled issue does not change the scoreboard.
- ALU writeback to a busy register is accepted and does not clear the busy bit; issue-stage WAW stall prevents this case.

## Timing
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, busy=0, round-robin pointer favours ALU first.
- alu_ready and mem_ready are 0 while rst=0.
- Latency: handshake in cycle T → RegWrite pulse in cycle T+1, lasting exactly one cycle per accepted request.
- Throughput: one write per cycle. Back-to-back grants produce consecutive RegWrite cycles.
- The scoreboard clear is visible in busy and iss_stall from cycle T+1, the same cycle the register file write occurs. Data is readable from the file in T+2.
- Reset asserted mid-operation: all state returns immediately to reset values; any in-flight write is dropped.

## Configuration
- RR_ARB_EN defined: round-robin arbitration, as above.
- RR_ARB_EN undefined:
  - Fixed priority, memory over ALU.
  - No pointer register exists.
  - ALU ready = alu_valid & !mem_valid.

## Structure
- Shared package holds:
  - REG_ADDR_W=5 and NUM_REGS=32
  - requester id enum (REQ_ALU, REQ_MEM) used for the grant and the pointer
- One sub-module, wb_scoreboard: busy vector with set/clear ports and the three-operand stall compare.
- Arbiter and write registers stay in the top module.

## Test plan
- Reset: hold rst=0 with both valids high → RegWrite=0, both readies 0, busy=0. Release → first grant goes to ALU.
- Single request: ALU rd=5, data=0x0000_00AA at T → T+1 RegWrite=1, WriteReg=5, WriteData=0xAA; T+2 RegWrite=0.
- Contention: both valid for 4 cycles (ALU rd=1, MEM rd=2) → grants ALU, MEM, ALU, MEM with RR_ARB_EN; MEM every cycle and alu_ready=0 without it.
- Scoreboard:
  - issue long rd=7 → busy[7]=1.
  - issue with rs1=7 → iss_stall=1.
  - MEM writeback rd=7 accepted at T → busy[7]=0 and stall drops at T+1.
- Simultaneous set/clear: MEM writeback rd=9 accepted while a long issue to rd=9 proceeds → busy[9] stays 1.
- rd=0 and mid-op reset:
  - ALU rd=0 accepted → RegWrite stays 0 and busy[0]=0.
  - Assert rst in the cycle after a grant → RegWrite forced 0 immediately.
